umax_reduce: RTL and testbench



---
 rtl/umax_pkg.sv | 24 ++
 rtl/umax2.sv | 26 ++
 rtl/umax_reduce.sv | 129 ++++++++++++
 tb/tb_umax_reduce.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/umax_pkg.sv
// Shared types and helpers for the unsigned-maximum stream reducer.
package umax_pkg;

  localparam int unsigned UMAX_WIDTH     = 32;
  localparam int unsigned UMAX_CNT_W     = 16;
  localparam int unsigned UMAX_CNT_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Increment v, saturating at 2^w-1; counters up to 32 bits wide are supported.
  function automatic logic [UMAX_CNT_W_MAX-1:0] sat_inc(
    input logic [UMAX_CNT_W_MAX-1:0] v,
    input int unsigned               w
  );
    logic [UMAX_CNT_W_MAX-1:0] lim;
    lim = (w >= UMAX_CNT_W_MAX) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/umax2.sv
// Combinational two-operand unsigned max with a strict a>b flag.
module umax2 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] max,
  output logic         gt
);

  // The first differing bit from the MSB down decides the order.
  always_comb begin
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        gt      = a[i];
        decided = 1'b1;
      end
    end
  end

  assign max = gt ? a : b;

endmodule

// File: rtl/umax_reduce.sv
// Streaming unsigned-maximum reducer: folds a packet into max, first index and beat count.
//   state | meaning
//   IDLE  | no beat of the current packet taken yet
//   ACCUM | at least one beat taken, last not yet seen
//   HOLD  | result presented until the consumer takes it
module umax_reduce
  import umax_pkg::*;
#(
  parameter int unsigned WIDTH = UMAX_WIDTH,
  parameter int unsigned CNT_W = UMAX_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_max_q, acc_max_d;
  logic [CNT_W-1:0] acc_idx_q, acc_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] out_max_q, out_max_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic [WIDTH-1:0] cand;
  logic             in_gt;

  umax2 #(.W(WIDTH)) u_umax2 (
    .a   (in_data),
    .b   (acc_max_q),
    .max (cand),
    .gt  (in_gt)
  );

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_max_d   = acc_max_q;
    acc_idx_d   = acc_idx_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_max_d = in_data;
          acc_idx_d = '0;
          cnt_d     = CNT_W'(1);
          ovf_d     = 1'b0;
          state_d   = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Strict compare keeps the earliest index on ties.
          if (in_gt) begin
            acc_max_d = cand;
            acc_idx_d = cnt_q;
          end
          cnt_d   = CNT_W'(sat_inc(UMAX_CNT_W_MAX'(cnt_q), CNT_W));
          ovf_d   = ovf_q | (cnt_q == CNT_MAX);
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == HOLD) && (state_q != HOLD)) begin
      out_max_d   = acc_max_d;
      out_idx_d   = acc_idx_d;
      out_count_d = cnt_d;
      out_ovf_d   = ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_max_q   <= '0;
      acc_idx_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_max_q   <= acc_max_d;
      acc_idx_q   <= acc_idx_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_umax_reduce.sv
// Scoreboard bench for umax_reduce: default-width instance plus a CNT_W=4 instance for overflow.
module tb_umax_reduce;

  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, out_ovf;
  logic [W-1:0]  out_max;
  logic [CW-1:0] out_idx, out_count;

  logic           in_valid4 = 1'b0, in_last4 = 1'b0, out_ready4 = 1'b1;
  logic [W-1:0]   in_data4 = '0;
  logic           in_ready4, out_valid4, out_ovf4;
  logic [W-1:0]   out_max4;
  logic [CW4-1:0] out_idx4, out_count4;

  typedef struct packed {
    logic [W-1:0]  mx;
    logic [CW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  umax_reduce #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_count(out_count), .out_ovf(out_ovf)
  );

  umax_reduce #(.WIDTH(W), .CNT_W(CW4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_max(out_max4), .out_idx(out_idx4), .out_count(out_count4), .out_ovf(out_ovf4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Result monitors: one pop per handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual max=0x%0h cnt=%0d required none", out_max, out_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("res_max",   64'(out_max),   64'(e.mx));
        check("res_idx",   64'(out_idx),   64'(e.idx));
        check("res_count", 64'(out_count), 64'(e.cnt));
        check("res_ovf",   64'(out_ovf),   64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result4 actual max=0x%0h cnt=%0d required none", out_max4, out_count4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("res4_max",   64'(out_max4),   64'(e.mx));
        check("res4_idx",   64'(out_idx4),   64'(e.idx));
        check("res4_count", 64'(out_count4), 64'(e.cnt));
        check("res4_ovf",   64'(out_ovf4),   64'(e.ovf));
      end
    end
  end

  // Present a beat from posedge+1 and return at posedge+1 after it is accepted.
  task automatic send(input logic [W-1:0] d, input logic l, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout actual in_ready=0 required 1");
    end
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_max",   64'(out_max),   64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst4_out_valid", 64'(out_valid4), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 5, 9, 3, 9(last): first 9 wins the tie
    q.push_back('{mx: 32'd9, idx: 16'd1, cnt: 16'd4, ovf: 1'b0});
    send(32'd5, 1'b0, w);
    send(32'd9, 1'b0, w);
    send(32'd3, 1'b0, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("accum_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    send(32'd9, 1'b1, w);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    idle_cycles(1);

    // single all-ones beat held by the consumer
    out_ready = 1'b0;
    q.push_back('{mx: 32'hFFFF_FFFF, idx: 16'd0, cnt: 16'd1, ovf: 1'b0});
    send(32'hFFFF_FFFF, 1'b1, w);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready",  64'(in_ready),  64'd0);
      check("hold_out_max",   64'(out_max),   64'hFFFF_FFFF);
      check("hold_out_idx",   64'(out_idx),   64'd0);
      check("hold_out_count", 64'(out_count), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle_cycles(2);

    // unsigned boundary: MSB-set value beats 0x7FFFFFFF
    q.push_back('{mx: 32'h8000_0000, idx: 16'd1, cnt: 16'd2, ovf: 1'b0});
    send(32'h7FFF_FFFF, 1'b0, w);
    send(32'h8000_0000, 1'b1, w);
    idle_cycles(3);

    // idle gap inside a packet, tie at the end
    q.push_back('{mx: 32'd3, idx: 16'd0, cnt: 16'd3, ovf: 1'b0});
    send(32'd3, 1'b0, w);
    idle_cycles(2);
    send(32'd0, 1'b0, w);
    send(32'd3, 1'b1, w);
    idle_cycles(3);

    // all-zero packet
    q.push_back('{mx: 32'd0, idx: 16'd0, cnt: 16'd2, ovf: 1'b0});
    send(32'd0, 1'b0, w);
    send(32'd0, 1'b1, w);
    idle_cycles(3);

    // back-to-back packets: second first beat waits exactly one HOLD cycle
    q.push_back('{mx: 32'd2, idx: 16'd1, cnt: 16'd2, ovf: 1'b0});
    q.push_back('{mx: 32'd7, idx: 16'd0, cnt: 16'd1, ovf: 1'b0});
    send(32'd1, 1'b0, w);
    send(32'd2, 1'b1, w);
    send(32'd7, 1'b1, w);
    check("b2b_wait_cycles", 64'(w), 64'd1);
    idle_cycles(3);

    // reset mid-packet discards partial state
    send(32'd100, 1'b0, w);
    send(32'd200, 1'b0, w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_out_max",   64'(out_max),   64'd0);
    check("midrst_out_count", 64'(out_count), 64'd0);
    @(posedge clk);
    #1;
    q.push_back('{mx: 32'd4, idx: 16'd0, cnt: 16'd1, ovf: 1'b0});
    send(32'd4, 1'b1, w);
    idle_cycles(3);

    // overflow on the 4-bit counter instance: 17 beats of 1
    q4.push_back('{mx: 32'd1, idx: 16'd0, cnt: 16'd15, ovf: 1'b1});
    in_valid4 = 1'b1;
    in_data4  = 32'd1;
    for (int b = 1; b <= 17; b++) begin
      in_last4 = (b == 17);
      @(posedge clk);
      #1;
    end
    in_valid4 = 1'b0;
    in_last4  = 1'b0;

    for (int i = 0; i < 20 && (q.size() != 0 || q4.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    check("queue_drained",  64'(q.size()),  64'd0);
    check("queue4_drained", 64'(q4.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
